obi_mem_arbiter: RTL
====================

// Module: obi_mem_arbiter
// PURPOSE
//  Shares one single-ported OBI-style memory bus between the core's fetch port
//  (imem) and load/store port (dmem). Sits between the core wrapper and the
//  memory model. Allows one outstanding transaction. Priority is dmem-first,
//  with an imem anti-starvation guarantee. A response timeout flags hung memory.
// PARAMETERS
//  ADDR_W      32   address width, all ports
//  DATA_W      32   data width, all ports; byte-enable width is DATA_W/8
//  MAX_STARVE  4    consecutive dmem wins allowed while imem waits (>=1)
//  TIMEOUT     255  cycles in RESP before an error response; 0 = disabled
// PORTS
//  clk_i          in   1         clock, rising edge
//  rst_i          in   1         asynchronous reset, active-high
//  imem_req_i     in   1         fetch request
//  imem_addr_i    in   ADDR_W    fetch address
//  imem_gnt_o     out  1         fetch request accepted by memory
//  imem_rvalid_o  out  1         fetch response valid (1-cycle pulse)
//  imem_rdata_o   out  DATA_W    fetch read data
//  imem_err_o     out  1         fetch response is a timeout error
//  dmem_req_i     in   1         data request
//  dmem_we_i      in   1         1 = write, 0 = read
//  dmem_be_i      in   DATA_W/8  byte enables
//  dmem_addr_i    in   ADDR_W    data address
//  dmem_wdata_i   in   DATA_W    write data
//  dmem_gnt_o     out  1         data request accepted by memory
//  dmem_rvalid_o  out  1         data response valid (also for writes)
//  dmem_rdata_o   out  DATA_W    data read data
//  dmem_err_o     out  1         data response is a timeout error
//  mem_req_o      out  1         memory request
//  mem_we_o       out  1         memory write enable
//  mem_be_o       out  DATA_W/8  memory byte enables
//  mem_addr_o     out  ADDR_W    memory address
//  mem_wdata_o    out  DATA_W    memory write data
//  mem_gnt_i      in   1         memory accepts mem_req_o this cycle
//  mem_rvalid_i   in   1         memory response valid
//  mem_rdata_i    in   DATA_W    memory read data
// BEHAVIOUR
//  - Reset (rst_i=1, asynchronous): state=IDLE, starve_cnt=0, timer=0. All outputs 0.
//    Any in-flight transaction is abandoned; no response is delivered for it.
//  - FSM states: IDLE, REQ, RESP.
//  - IDLE:
//    - If any *_req_i is high, pick the owner and latch owner, we, be, addr, wdata.
//      Imem latches we=0 and be=all-ones. Go to REQ next cycle.
//    - Owner choice:
//      - dmem only -> dmem; imem only -> imem.
//      - Both requesting -> dmem, unless starve_cnt==MAX_STARVE -> imem.
//  - starve_cnt: +1 when dmem wins while imem_req_i=1; cleared when imem wins;
//    saturates at MAX_STARVE.
//  - REQ: mem_req_o=1, driven from the latched fields, which hold stable.
//    - owner gnt_o = mem_gnt_i, combinational, same cycle.
//    - On mem_gnt_i=1 go to RESP and clear timer.
//  - RESP: mem_req_o=0.
//    - On mem_rvalid_i: owner rvalid_o=1 and rdata_o=mem_rdata_i, same cycle,
//      combinational; go to IDLE.
//    - Otherwise timer+1. If TIMEOUT!=0 and timer reaches TIMEOUT: owner
//      rvalid_o=1, err_o=1, rdata_o=0; go to IDLE.
//  - Non-owner gnt/rvalid/err are always 0. rdata_o is 0 whenever rvalid_o=0.
//  - mem_rvalid_i outside RESP (stray or late after timeout) is ignored.
//  - Once latched, a transaction completes even if the requester drops req.
//    A req dropped before selection is never issued.
//  - Min latency: req in IDLE at cycle N -> mem_req_o at N+1 -> rvalid at N+2
//    (immediate gnt, rvalid one cycle later). Peak rate: one transaction per
//    3 cycles.
//  - Requesters must hold req/addr/wdata until gnt (OBI). Arbiter never reorders.
// TESTING
//  1. Imem-only read at 0x3000, gnt same cycle, rvalid next cycle with 0x00000073
//     -> imem_rvalid_o at N+2 with rdata 0x00000073; dmem outputs stay 0.
//  2. Dmem write addr 0x100, be=0011, wdata 0xDEADBEEF, both requesting
//     -> dmem issued first with mem_we_o=1, mem_be_o=0011; imem issued next.
//  3. Both req held continuously, MAX_STARVE=4 -> grant order D,D,D,D,I,D,D,D,D,I.
//  4. mem_gnt_i held low 5 cycles -> mem_req_o and latched addr stable for all
//     5 cycles; gnt_o pulses once.
//  5. TIMEOUT=8, rvalid never comes -> owner rvalid_o=1, err_o=1, rdata_o=0
//     exactly 8 cycles after gnt. Later stray mem_rvalid_i -> no output.
//  6. rst_i asserted mid-RESP -> all outputs 0 immediately; no response after
//     release; next request served normally with starve_cnt=0.

Source files
------------

// File: rtl/obi_mem_arbiter.sv
// Two-port (fetch / load-store) arbiter onto a single OBI-style memory bus.
// One outstanding transaction, dmem-first priority with imem anti-starvation, response timeout.
module obi_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_STARVE = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,

  input  logic                imem_req_i,
  input  logic [ADDR_W-1:0]   imem_addr_i,
  output logic                imem_gnt_o,
  output logic                imem_rvalid_o,
  output logic [DATA_W-1:0]   imem_rdata_o,
  output logic                imem_err_o,

  input  logic                dmem_req_i,
  input  logic                dmem_we_i,
  input  logic [DATA_W/8-1:0] dmem_be_i,
  input  logic [ADDR_W-1:0]   dmem_addr_i,
  input  logic [DATA_W-1:0]   dmem_wdata_i,
  output logic                dmem_gnt_o,
  output logic                dmem_rvalid_o,
  output logic [DATA_W-1:0]   dmem_rdata_o,
  output logic                dmem_err_o,

  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  localparam int BE_W = DATA_W / 8;
  localparam int SC_W = $clog2(MAX_STARVE + 1);
  localparam int TM_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(MAX_STARVE);
  localparam logic [TM_W-1:0] TM_LAST    = (TIMEOUT > 0) ? TM_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t            state_reg, state_next;
  logic              owner_dmem_reg;
  logic              we_reg;
  logic [BE_W-1:0]   be_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [SC_W-1:0]   starve_reg;
  logic [TM_W-1:0]   timer_reg;

  logic any_req;
  logic pick_dmem;
  logic timeout_hit;

  assign any_req   = imem_req_i | dmem_req_i;
  // dmem wins ties unless imem has already been passed over MAX_STARVE times in a row
  assign pick_dmem = dmem_req_i && !(imem_req_i && (starve_reg == STARVE_MAX));

  // The timer counts completed RESP cycles, so the error fires on the
  // TIMEOUT-th RESP cycle, i.e. TIMEOUT cycles after the grant.
  assign timeout_hit = (TIMEOUT != 0) && (state_reg == RESP) && !mem_rvalid_i
                       && (timer_reg == TM_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg      <= IDLE;
      owner_dmem_reg <= 1'b0;
      we_reg         <= 1'b0;
      be_reg         <= '0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      starve_reg     <= '0;
      timer_reg      <= '0;
    end else begin
      state_reg <= state_next;

      if (state_reg == IDLE && any_req) begin
        owner_dmem_reg <= pick_dmem;
        if (pick_dmem) begin
          we_reg    <= dmem_we_i;
          be_reg    <= dmem_be_i;
          addr_reg  <= dmem_addr_i;
          wdata_reg <= dmem_wdata_i;
          if (imem_req_i && (starve_reg != STARVE_MAX))
            starve_reg <= starve_reg + SC_W'(1);
        end else begin
          we_reg     <= 1'b0;
          be_reg     <= '1;
          addr_reg   <= imem_addr_i;
          wdata_reg  <= '0;
          starve_reg <= '0;
        end
      end

      if (state_reg == REQ)
        timer_reg <= '0;
      else if (state_reg == RESP)
        timer_reg <= timer_reg + TM_W'(1);
    end
  end

  always_comb begin
    state_next    = state_reg;
    imem_gnt_o    = 1'b0;
    imem_rvalid_o = 1'b0;
    imem_rdata_o  = '0;
    imem_err_o    = 1'b0;
    dmem_gnt_o    = 1'b0;
    dmem_rvalid_o = 1'b0;
    dmem_rdata_o  = '0;
    dmem_err_o    = 1'b0;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    mem_be_o      = '0;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;

    case (state_reg)
      IDLE: begin
        if (any_req)
          state_next = REQ;
      end

      REQ: begin
        mem_req_o   = 1'b1;
        mem_we_o    = we_reg;
        mem_be_o    = be_reg;
        mem_addr_o  = addr_reg;
        mem_wdata_o = wdata_reg;
        if (owner_dmem_reg)
          dmem_gnt_o = mem_gnt_i;
        else
          imem_gnt_o = mem_gnt_i;
        if (mem_gnt_i)
          state_next = RESP;
      end

      RESP: begin
        if (mem_rvalid_i) begin
          if (owner_dmem_reg) begin
            dmem_rvalid_o = 1'b1;
            dmem_rdata_o  = mem_rdata_i;
          end else begin
            imem_rvalid_o = 1'b1;
            imem_rdata_o  = mem_rdata_i;
          end
          state_next = IDLE;
        end else if (timeout_hit) begin
          if (owner_dmem_reg) begin
            dmem_rvalid_o = 1'b1;
            dmem_err_o    = 1'b1;
          end else begin
            imem_rvalid_o = 1'b1;
            imem_err_o    = 1'b1;
          end
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule
